// File: rtl/matmul_job_sequencer.sv
// Sequences one 4x4 matrix-multiply job: clear the multiplier, stream operands from the
// source SRAM, wait out the compute latency, then drain result beats to the destination SRAM.
`timescale 1ns/1ps

module matmul_job_sequencer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned MATRIX_WIDTH = 4,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MULT_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             src_base_i,
    input  logic [ADDR_W-1:0]             dst_base_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          mem_rd_en_o,
    output logic [ADDR_W-1:0]             mem_rd_addr_o,
    input  logic [NUM_ELEMENTS*WIDTH-1:0] mem_rd_data_i,
    output logic                          mm_reset_o,
    output logic                          mm_read_en_o,
    output logic [NUM_ELEMENTS*WIDTH-1:0] mm_rdata_o,
    output logic                          mm_write_en_o,
    input  logic [NUM_ELEMENTS*WIDTH-1:0] mm_res_i,
    output logic                          mem_wr_en_o,
    output logic [ADDR_W-1:0]             mem_wr_addr_o,
    output logic [NUM_ELEMENTS*WIDTH-1:0] mem_wr_data_o
);

    localparam int unsigned LoadBeats  = MATRIX_WIDTH * MATRIX_WIDTH / 2;
    localparam int unsigned StoreBeats = MATRIX_WIDTH;
    localparam int unsigned CntMaxLs   = (LoadBeats > StoreBeats) ? LoadBeats : StoreBeats;
    localparam int unsigned CntMax     = (CntMaxLs > MULT_LATENCY) ? CntMaxLs : MULT_LATENCY;
    localparam int unsigned CntW       = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StDrain,
        StWait,
        StStore,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              mm_read_en_q, mm_read_en_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            mm_read_en_q  <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            mm_read_en_q  <= mm_read_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
        end
    end

    // One shared counter serves as load beat, latency count and store beat in turn.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StLoad;
            end
            StLoad: begin
                if (cnt_q == CntW'(LoadBeats - 1)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CntW'(MULT_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = StStore;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStore: begin
                if (cnt_q == CntW'(StoreBeats - 1)) begin
                    cnt_d   = '0;
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != StIdle) && (state_q != StDone);
        done_o        = (state_q == StDone);
        mem_rd_en_o   = (state_q == StLoad);
        mem_rd_addr_o = src_q + ADDR_W'(cnt_q);
        mm_write_en_o = (state_q == StStore);
        mm_reset_o    = reset || (state_q == StClear);

        // Source SRAM and multiplier both have one cycle of latency, so strobes trail by one.
        mm_read_en_d  = mem_rd_en_o;
        mem_wr_en_d   = mm_write_en_o;
        mem_wr_addr_d = mm_write_en_o ? (dst_q + ADDR_W'(cnt_q)) : mem_wr_addr_q;

        mm_read_en_o  = mm_read_en_q;
        mem_wr_en_o   = mem_wr_en_q;
        mem_wr_addr_o = mem_wr_addr_q;
        mm_rdata_o    = mem_rd_data_i;
        mem_wr_data_o = mm_res_i;
    end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench: three sequencers (L=3 main, L=1, L=255) with a source SRAM and a
// behavioural 4x4 multiplier attached to the main instance.
`timescale 1ns/1ps

module tb_matmul_job_sequencer;

    localparam int NInst = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  src_base = '0;
    logic [9:0]  dst_base = '0;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] mm_res = '0;

    logic        busy [NInst];
    logic        done [NInst];
    logic        rd_en [NInst];
    logic [9:0]  rd_addr [NInst];
    logic        mmr [NInst];
    logic        mm_rd [NInst];
    logic [31:0] mm_rdata [NInst];
    logic        mm_wr [NInst];
    logic        wr_en [NInst];
    logic [9:0]  wr_addr [NInst];
    logic [31:0] wr_data [NInst];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NInst; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 3 : ((g == 1) ? 1 : 255);
        matmul_job_sequencer #(.MULT_LATENCY(Lat)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start_i      (start),
            .src_base_i   (src_base),
            .dst_base_i   (dst_base),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .mem_rd_en_o  (rd_en[g]),
            .mem_rd_addr_o(rd_addr[g]),
            .mem_rd_data_i(mem_rd_data),
            .mm_reset_o   (mmr[g]),
            .mm_read_en_o (mm_rd[g]),
            .mm_rdata_o   (mm_rdata[g]),
            .mm_write_en_o(mm_wr[g]),
            .mm_res_i     (mm_res),
            .mem_wr_en_o  (wr_en[g]),
            .mem_wr_addr_o(wr_addr[g]),
            .mem_wr_data_o(wr_data[g])
        );
    end

    // Source SRAM, one-cycle read latency, served to the main instance.
    logic [31:0] src_mem [1024];
    always @(posedge clk) mem_rd_data <= src_mem[rd_addr[0]];

    // Behavioural multiplier: unpacks column-major two-row operand beats, emits rows of A*B.
    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];
    int ld = 0;
    int st = 0;
    int mc, mr;

    function automatic logic [31:0] row_prod(input int j);
        logic [7:0] s;
        logic [31:0] r;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            s = '0;
            for (int m = 0; m < 4; m++) s = s + 8'(ma[j][m] * mb[m][col]);
            r = {r[23:0], s};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mmr[0]) begin
            ld <= 0;
            st <= 0;
        end else begin
            if (mm_rd[0] && ld < 8) begin
                mc = ld / 2;
                mr = 2 * (ld % 2);
                ma[mr][mc]   <= mm_rdata[0][31:24];
                ma[mr+1][mc] <= mm_rdata[0][23:16];
                mb[mr][mc]   <= mm_rdata[0][15:8];
                mb[mr+1][mc] <= mm_rdata[0][7:0];
                ld <= ld + 1;
            end
            if (mm_wr[0] && st < 4) begin
                mm_res <= row_prod(st);
                st <= st + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // A = identity, B[i][j] = 4i+j.
    task automatic load_src(input logic [9:0] base);
        int c, r;
        logic [9:0] a;
        for (int b = 0; b < 8; b++) begin
            c = b / 2;
            r = 2 * (b % 2);
            a = base + 10'(b);
            src_mem[a] = {8'((r == c) ? 1 : 0), 8'((r + 1 == c) ? 1 : 0),
                          8'(4 * r + c), 8'(4 * (r + 1) + c)};
        end
    endtask

    function automatic logic [31:0] brow(input int j);
        return {8'(4 * j), 8'(4 * j + 1), 8'(4 * j + 2), 8'(4 * j + 3)};
    endfunction

    // {mm_reset, busy, done, mem_rd_en, mm_read_en, mm_write_en, mem_wr_en} at cycle k.
    function automatic logic [6:0] exp_ctl(input int k, input int l);
        return {k == 1, k >= 1 && k <= 15 + l, k == 16 + l, k >= 2 && k <= 9, k >= 3 && k <= 10,
                k >= 11 + l && k <= 14 + l, k >= 12 + l && k <= 15 + l};
    endfunction

    function automatic logic [6:0] obs_ctl();
        return {mmr[0], busy[0], done[0], rd_en[0], mm_rd[0], mm_wr[0], wr_en[0]};
    endfunction

    int done_cnt [NInst];
    int done_cyc [NInst];
    int last_rd [NInst];
    int first_wr [NInst];

    // Call just after a tick with the main instance idle; that cycle becomes cycle 0.
    task automatic run_job(input logic [9:0] sb, input logic [9:0] db, input bit pulse,
                           input int ncyc);
        logic [6:0] e;
        logic [9:0] a;
        for (int i = 0; i < NInst; i++) begin
            done_cnt[i] = 0;
            done_cyc[i] = 0;
            last_rd[i]  = 0;
            first_wr[i] = 0;
        end
        src_base = sb;
        dst_base = db;
        start    = 1'b1;
        check("busy@0", 32'(busy[0]), 32'd0);
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            start = 1'b0;
            if (pulse && (k == 5 || k == 12)) begin
                start    = 1'b1;
                src_base = ~sb;
                dst_base = ~db;
            end
            e = exp_ctl(k, 3);
            check($sformatf("ctl@%0d", k), 32'(obs_ctl()), 32'(e));
            if (e[3]) begin
                a = sb + 10'(k - 2);
                check($sformatf("rd_addr@%0d", k), 32'(rd_addr[0]), 32'(a));
            end
            if (e[0]) begin
                a = db + 10'(k - 15);
                check($sformatf("wr_addr@%0d", k), 32'(wr_addr[0]), 32'(a));
                check($sformatf("wr_data@%0d", k), wr_data[0], brow(k - 15));
            end
            for (int i = 0; i < NInst; i++) begin
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = k;
                end
                if (mm_rd[i]) last_rd[i] = k;
                if (mm_wr[i] && first_wr[i] == 0) first_wr[i] = k;
            end
        end
    endtask

    int nd, bad_done, ovl;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ctl", 32'(obs_ctl()), 32'b1000000);
        check("rst_rd_addr", 32'(rd_addr[0]), 32'd0);
        check("rst_wr_addr", 32'(wr_addr[0]), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_ctl", 32'(obs_ctl()), 32'd0);

        // Single job plus latency variants sharing the same start
        load_src(10'h010);
        run_job(10'h010, 10'h100, 1'b0, 280);
        check("l3_done_cnt", 32'(done_cnt[0]), 32'd1);
        check("l1_done_cyc", 32'(done_cyc[1]), 32'd17);
        check("l1_done_cnt", 32'(done_cnt[1]), 32'd1);
        check("l255_done_cyc", 32'(done_cyc[2]), 32'd271);
        check("l255_done_cnt", 32'(done_cnt[2]), 32'd1);
        check("l3_gap", 32'(first_wr[0] - last_rd[0]), 32'd4);
        check("l1_gap", 32'(first_wr[1] - last_rd[1]), 32'd2);
        check("l255_gap", 32'(first_wr[2] - last_rd[2]), 32'd256);

        // start held high: back-to-back jobs at 0, 20, 40
        do_reset();
        src_base = 10'h010;
        dst_base = 10'h100;
        start = 1'b1;
        nd = 0;
        bad_done = 0;
        ovl = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done[0]) begin
                nd++;
                if (!(k == 19 || k == 39 || k == 59)) bad_done++;
            end
            if (rd_en[0] && wr_en[0]) ovl++;
            if (k == 21 || k == 41) check($sformatf("held_clear@%0d", k), 32'(mmr[0]), 32'd1);
            if (k == 59) start = 1'b0;
        end
        check("held_done_cnt", 32'(nd), 32'd3);
        check("held_done_when", 32'(bad_done), 32'd0);
        check("held_overlap", 32'(ovl), 32'd0);

        // start pulses during a job are ignored and do not recapture bases
        do_reset();
        run_job(10'h010, 10'h100, 1'b1, 40);
        check("pulse_done_cnt", 32'(done_cnt[0]), 32'd1);

        // Reset mid-LOAD abandons the job
        do_reset();
        src_base = 10'h010;
        dst_base = 10'h100;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            start = 1'b0;
            if (k == 5) check("pre_rst_rd_en", 32'(rd_en[0]), 32'd1);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_mmr", 32'(mmr[0]), 32'd1);
        tick();
        check("mid_rst_ctl", 32'(obs_ctl()), 32'b1000000);
        reset = 1'b0;
        nd = 0;
        for (int k = 8; k <= 40; k++) begin
            tick();
            if (done[0] || busy[0]) nd++;
        end
        check("mid_rst_quiet", 32'(nd), 32'd0);
        run_job(10'h010, 10'h100, 1'b0, 22);

        // Address wrap
        do_reset();
        load_src(10'h3FC);
        run_job(10'h3FC, 10'h3FE, 1'b0, 22);
        check("wrap_done_cnt", 32'(done_cnt[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
